// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with per-digit
// active-low enables and leading-zero blanking for a seven-segment stage.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  binary,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_n_enable,
  output logic                  overflow
);

  // Number of decimal digits needed to hold 2^w - 1.
  function automatic int calc_acc_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        v = v / 64'd10;
        n = n + 1;
      end else begin
        v = v;
      end
    end
    return (n < 1) ? 1 : n;
  endfunction

  // Double-dabble digit correction applied before each shift.
  function automatic logic [3:0] adj_digit(input logic [3:0] d);
    if (d >= 4'd5) begin
      return d + 4'd3;
    end else begin
      return d;
    end
  endfunction

  localparam int CALC_DIGITS = calc_acc_digits(BIN_WIDTH);
  localparam int ACC_DIGITS  = (CALC_DIGITS > DIGITS) ? CALC_DIGITS : DIGITS;
  localparam int ACC_W       = 4 * ACC_DIGITS;
  localparam int CNT_W       = $clog2(BIN_WIDTH + 1);
  localparam logic [DIGITS-1:0] EN_RST = ~(DIGITS'(1'b1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [BIN_WIDTH-1:0]   sr_q, sr_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [4*DIGITS-1:0]    bcd_q, bcd_d;
  logic [DIGITS-1:0]      en_q, en_d;
  logic                   ovf_q, ovf_d;

  logic [ACC_W-1:0]       adj_s;
  logic [DIGITS-1:0]      en_s;
  logic                   ovf_s;
  logic                   zero_above_s;

  // Corrected accumulator, truncation overflow and blanking of the final value.
  always_comb begin
    adj_s        = {ACC_W{1'b0}};
    en_s         = {DIGITS{1'b0}};
    ovf_s        = 1'b0;
    zero_above_s = 1'b1;
    for (int i = 0; i < ACC_DIGITS; i++) begin
      adj_s[4*i +: 4] = adj_digit(acc_q[4*i +: 4]);
    end
    for (int i = DIGITS; i < ACC_DIGITS; i++) begin
      ovf_s = ovf_s | (acc_q[4*i +: 4] != 4'd0);
    end
    // Blanking looks only at the truncated digits, even on overflow.
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above_s = zero_above_s & (acc_q[4*i +: 4] == 4'd0);
      en_s[i]      = zero_above_s;
    end
    en_s[0] = 1'b0;
  end

  // Next-state logic for the FSM and all datapath registers.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    en_d    = en_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          sr_d    = binary;
          acc_d   = {ACC_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(BIN_WIDTH)) begin
          state_d = DONE;
          done_d  = 1'b1;
          bcd_d   = acc_q[4*DIGITS-1:0];
          en_d    = en_s;
          ovf_d   = ovf_s;
        end else begin
          busy_d        = 1'b1;
          {acc_d, sr_d} = {adj_s[ACC_W-2:0], sr_q, 1'b0};
          cnt_d         = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      sr_q    <= {BIN_WIDTH{1'b0}};
      acc_q   <= {ACC_W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= {(4*DIGITS){1'b0}};
      en_q    <= EN_RST;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign bcd_out        = bcd_q;
  assign digit_n_enable = en_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed cases plus random values
// compared against an arithmetic decimal model.
module tb_bin_to_bcd_seq;

  localparam int BIN_WIDTH = 14;
  localparam int DIGITS    = 4;
  localparam int LATENCY   = BIN_WIDTH + 1;

  logic                 clk = 1'b0;
  logic                 n_reset;
  logic                 start;
  logic [BIN_WIDTH-1:0] binary;
  logic                 busy;
  logic                 done;
  logic [4*DIGITS-1:0]  bcd_out;
  logic [DIGITS-1:0]    digit_n_enable;
  logic                 overflow;

  int n_chk  = 0;
  int n_fail = 0;

  bin_to_bcd_seq #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .start          (start),
    .binary         (binary),
    .busy           (busy),
    .done           (done),
    .bcd_out        (bcd_out),
    .digit_n_enable (digit_n_enable),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: plain decimal arithmetic on the truncated value.
  function automatic logic [31:0] m_bcd(input int v);
    int t;
    logic [31:0] r;
    t = v % 10000;
    r = 32'd0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_en(input int v);
    int t;
    int p;
    logic [31:0] r;
    t = v % 10000;
    p = 1;
    r = 32'd0;
    for (int i = 1; i < DIGITS; i++) begin
      p = p * 10;
      r[i] = (t < p);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_conv(input int v);
    binary = BIN_WIDTH'(v);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // Waits for done after acceptance; optionally pulses start mid-conversion.
  task automatic wait_done(input string tag, input int v, input int pulse_cycle, input int pulse_val);
    int cyc;
    bit got;
    bit busy_ok;
    cyc = 0; got = 1'b0; busy_ok = 1'b1;
    chk({tag, "_busy_on"}, 32'(busy), 32'd1);
    while (cyc < 40 && !got) begin
      if (cyc == pulse_cycle) begin
        start  = 1'b1;
        binary = BIN_WIDTH'(pulse_val);
      end
      @(posedge clk); #1;
      start  = 1'b0;
      binary = BIN_WIDTH'($urandom_range(0, 16383));
      cyc++;
      if (done) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(LATENCY));
    chk({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    chk({tag, "_bcd"}, 32'(bcd_out), m_bcd(v));
    chk({tag, "_en"}, 32'(digit_n_enable), m_en(v));
    chk({tag, "_ovf"}, 32'(overflow), 32'(v > 9999));
  endtask

  task automatic convert(input string tag, input int v);
    start_conv(v);
    wait_done(tag, v, -1, 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int vals[8];
    n_reset = 1'b0;
    start   = 1'b0;
    binary  = '0;
    repeat (2) @(posedge clk);
    #1;
    n_reset = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_en", 32'(digit_n_enable), 32'hE);
    chk("rst_ovf", 32'(overflow), 32'd0);

    convert("zero", 0);
    chk("zero_en_const", 32'(digit_n_enable), 32'hE);
    convert("v9999", 9999);
    chk("v9999_bcd_const", 32'(bcd_out), 32'h9999);
    convert("v42", 42);
    chk("v42_en_const", 32'(digit_n_enable), 32'hC);
    convert("v16383", 16383);
    chk("v16383_bcd_const", 32'(bcd_out), 32'h6383);
    convert("v10005", 10005);
    chk("v10005_en_const", 32'(digit_n_enable), 32'hE);

    vals = '{9, 10, 99, 100, 999, 1000, 10000, 1};
    foreach (vals[i]) convert("edge", vals[i]);

    // Start during SHIFT is ignored.
    start_conv(1234);
    wait_done("ign", 1234, 5, 777);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("ign_single_done", 32'(seen), 32'd0);
    chk("ign_bcd_const", 32'(bcd_out), 32'h1234);

    // Back-to-back: start held during the done cycle.
    start_conv(500);
    wait_done("b2b_a", 500, -1, 0);
    start_conv(81);
    wait_done("b2b_b", 81, -1, 0);
    chk("b2b_bcd_const", 32'(bcd_out), 32'h0081);

    // Asynchronous reset mid-conversion.
    start_conv(1234);
    repeat (6) @(posedge clk);
    #3;
    n_reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_bcd", 32'(bcd_out), 32'd0);
    chk("arst_en", 32'(digit_n_enable), 32'hE);
    chk("arst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    n_reset = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("arst_no_done", 32'(seen), 32'd0);
    convert("after_rst", 321);

    repeat (25) convert("rand", int'($urandom_range(0, 16383)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
